// File: rtl/mcm_pkg.sv
// Shared encodings for the multicycle memory controller: request opcodes and FSM states.
package mcm_pkg;

  typedef enum logic [1:0] {
    OP_WRITE     = 2'b00,
    OP_READ      = 2'b01,
    OP_FETCH_ADD = 2'b10,
    OP_RSVD      = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    DECODE    = 3'b001,
    ACCESS    = 3'b010,
    WRITEBACK = 3'b011,
    DONE      = 3'b100
  } state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mcm_ram.sv
// Single-port word array with a synchronous write and a combinational read.
module mcm_ram
  import mcm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              in_range_s;

  assign in_range_s = ({1'b0, addr_i} < DEPTH_L);

  // Storage is deliberately left without reset; contents are undefined until written.
  always_ff @(posedge clk_i) begin
    if (we_i && in_range_s) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Out-of-range addresses read as zero instead of indexing past the array.
  always_comb begin
    rdata_o = '0;
    if (in_range_s) begin
      rdata_o = mem_q[addr_i];
    end else begin
      rdata_o = '0;
    end
  end

endmodule

// File: rtl/multicycle_mem_ctrl.sv
// Multicycle memory controller: DECODE/ACCESS/WRITEBACK/DONE sequencing with wait
// states, fetch-and-add, and range/opcode checking in front of mcm_ram.
module multicycle_mem_ctrl
  import mcm_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] read_data
);

  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sum_q, sum_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;

  logic              addr_ok_s;
  logic              we_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] ram_wdata_s;
  logic [DATA_W-1:0] ram_rdata_s;

  assign addr_ok_s = ({1'b0, addr_q} < DEPTH_L);
  // A reset in the same cycle abandons any pending store.
  assign ram_we_s  = we_s & ~rst;

  mcm_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we_s),
    .addr_i  (addr_q),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    rdata_d     = rdata_q;
    we_s        = 1'b0;
    ram_wdata_s = wdata_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op_e'(op);
          addr_d  = addr;
          wdata_d = write_data;
          state_d = DECODE;
        end else begin
          state_d = IDLE;
        end
      end
      DECODE: begin
        if ((op_q == OP_RSVD) || !addr_ok_s) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d   = WAIT_L;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          case (op_q)
            OP_WRITE: begin
              we_s    = 1'b1;
              state_d = DONE;
            end
            OP_READ: begin
              rdata_d = ram_rdata_s;
              state_d = DONE;
            end
            OP_FETCH_ADD: begin
              rdata_d = ram_rdata_s;
              sum_d   = ram_rdata_s + wdata_q;
              state_d = WRITEBACK;
            end
            default: begin
              state_d = DONE;
            end
          endcase
        end
      end
      WRITEBACK: begin
        we_s        = 1'b1;
        ram_wdata_s = sum_q;
        state_d     = DONE;
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Outputs are computed from the next state so they appear registered in that state.
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    error_d = (state_d == DONE) && err_d;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= {CNT_W{1'b0}};
      sum_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign read_data = rdata_q;

endmodule

// File: tb/tb_multicycle_mem_ctrl.sv
// Self-checking bench: two controller instances (no wait states / full depth, and
// three wait states / depth 200) checked against a behavioural memory model.
module tb_multicycle_mem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst_s, start_s, busy_w, done_w, error_w;
  logic [1:0][1:0] op_s;
  logic [1:0][7:0] addr_s, wdata_s, rdata_w;

  int errors = 0;
  int checks = 0;

  logic [7:0] mm [2][256];
  logic [7:0] mr [2];

  multicycle_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst_s[0]), .start(start_s[0]), .op(op_s[0]), .addr(addr_s[0]),
    .write_data(wdata_s[0]), .busy(busy_w[0]), .done(done_w[0]), .error(error_w[0]),
    .read_data(rdata_w[0]));

  multicycle_mem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst_s[1]), .start(start_s[1]), .op(op_s[1]), .addr(addr_s[1]),
    .write_data(wdata_s[1]), .busy(busy_w[1]), .done(done_w[1]), .error(error_w[1]),
    .read_data(rdata_w[1]));

  function automatic int wc(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int dep(input int d);
    return (d == 0) ? 256 : 200;
  endfunction

  // mode 0: single start pulse; mode 1: junk starts while busy; mode 2: start held high
  task automatic do_req(input int d, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] wd, input int mode);
    int lat, cyc, busy_low;
    bit err;
    logic [7:0] exp_rd;
    err = (op == 2'b11) || (int'(a) >= dep(d));
    lat = err ? 2 : ((op == 2'b10) ? 4 + wc(d) : 3 + wc(d));
    if (!err) begin
      case (op)
        2'b00: mm[d][a] = wd;
        2'b01: mr[d] = mm[d][a];
        2'b10: begin mr[d] = mm[d][a]; mm[d][a] = mm[d][a] + wd; end
        default: ;
      endcase
    end
    exp_rd = mr[d];
    start_s[d] = 1'b1; op_s[d] = op; addr_s[d] = a; wdata_s[d] = wd;
    @(posedge clk); #1;
    if (mode != 2) start_s[d] = 1'b0;
    cyc = 0; busy_low = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (busy_w[d] !== 1'b1) busy_low++;
      if (done_w[d] === 1'b1) break;
      if (mode == 1) begin
        start_s[d] = 1'b1;
        op_s[d]    = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
        addr_s[d]  = a;
        wdata_s[d] = ~wd ^ 8'($urandom_range(1, 255));
      end
    end
    checks++;
    if (done_w[d] !== 1'b1 || cyc != lat) begin
      errors++;
      $display("FAIL latency dut%0d op=%0d addr=%h: done=%b at cycle %0d, need cycle %0d", d, op, a, done_w[d], cyc, lat);
    end
    checks++;
    if (error_w[d] !== err) begin
      errors++;
      $display("FAIL error_flag dut%0d op=%0d addr=%h: got %b need %b", d, op, a, error_w[d], err);
    end
    checks++;
    if (rdata_w[d] !== exp_rd) begin
      errors++;
      $display("FAIL read_data dut%0d op=%0d addr=%h: got %h need %h", d, op, a, rdata_w[d], exp_rd);
    end
    checks++;
    if (busy_low != 0) begin
      errors++;
      $display("FAIL busy dut%0d op=%0d addr=%h: busy low in %0d cycles, need 0", d, op, a, busy_low);
    end
    @(posedge clk); #1;
    if (mode == 1) start_s[d] = 1'b0;
    checks++;
    if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || error_w[d] !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done dut%0d: busy=%b done=%b error=%b need 000", d, busy_w[d], done_w[d], error_w[d]);
    end
  endtask

  task automatic test_reset();
    rst_s = 2'b11; start_s = 2'b00;
    for (int d = 0; d < 2; d++) begin op_s[d] = 2'b00; addr_s[d] = 8'h00; wdata_s[d] = 8'h00; end
    repeat (3) @(posedge clk);
    #1;
    rst_s = 2'b00;
    for (int d = 0; d < 2; d++) begin
      mr[d] = 8'h00;
      checks++;
      if (busy_w[d] !== 1'b0 || done_w[d] !== 1'b0 || error_w[d] !== 1'b0 || rdata_w[d] !== 8'h00) begin
        errors++;
        $display("FAIL reset_state dut%0d: busy=%b done=%b error=%b read_data=%h need 0 0 0 00", d, busy_w[d], done_w[d], error_w[d], rdata_w[d]);
      end
    end
  endtask

  task automatic test_fill(input int d);
    for (int a = 0; a < dep(d); a++) do_req(d, 2'b00, 8'(a), 8'($urandom), 0);
  endtask

  task automatic test_write_read();
    do_req(0, 2'b00, 8'h10, 8'hA5, 0);
    do_req(0, 2'b01, 8'h10, 8'h00, 0);
    checks++;
    if (rdata_w[0] !== 8'hA5) begin
      errors++;
      $display("FAIL write_read_const: got %h need a5", rdata_w[0]);
    end
    do_req(0, 2'b01, 8'hFF, 8'h00, 0);
  endtask

  task automatic test_fetch_add();
    for (int d = 0; d < 2; d++) begin
      do_req(d, 2'b00, 8'h20, 8'hFE, 0);
      do_req(d, 2'b10, 8'h20, 8'h05, 0);
      do_req(d, 2'b01, 8'h20, 8'h00, 0);
      checks++;
      if (rdata_w[d] !== 8'h03) begin
        errors++;
        $display("FAIL fetch_add_wrap dut%0d: got %h need 03", d, rdata_w[d]);
      end
    end
  endtask

  task automatic test_wait_junk();
    do_req(1, 2'b00, 8'h40, 8'h3C, 0);
    do_req(1, 2'b01, 8'h40, 8'h00, 1);
    do_req(1, 2'b00, 8'h41, 8'h96, 1);
    do_req(1, 2'b01, 8'h40, 8'h00, 0);
    do_req(1, 2'b01, 8'h41, 8'h00, 0);
  endtask

  task automatic test_range();
    do_req(1, 2'b01, 8'h10, 8'h00, 0);
    do_req(1, 2'b01, 8'd200, 8'h00, 0);
    do_req(1, 2'b11, 8'h00, 8'h55, 0);
    do_req(1, 2'b00, 8'd199, 8'h6B, 0);
    do_req(1, 2'b10, 8'd255, 8'h01, 0);
    do_req(1, 2'b01, 8'd199, 8'h00, 0);
    do_req(0, 2'b11, 8'h00, 8'h00, 0);
  endtask

  task automatic test_reset_mid();
    int dones;
    do_req(1, 2'b00, 8'h30, 8'h11, 0);
    start_s[1] = 1'b1; op_s[1] = 2'b00; addr_s[1] = 8'h30; wdata_s[1] = 8'h77;
    @(posedge clk); #1; start_s[1] = 1'b0;
    @(posedge clk); #1; rst_s[1] = 1'b1;
    @(posedge clk); #1; rst_s[1] = 1'b0;
    mr[1] = 8'h00;
    checks++;
    if (busy_w[1] !== 1'b0 || rdata_w[1] !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_write: busy=%b read_data=%h need 0 00", busy_w[1], rdata_w[1]);
    end
    dones = 0;
    repeat (10) begin @(negedge clk); if (done_w[1] !== 1'b0) dones++; end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_mid_done: done high %0d cycles need 0", dones);
    end
    @(posedge clk); #1;
    do_req(1, 2'b01, 8'h30, 8'h00, 0);

    do_req(0, 2'b00, 8'h50, 8'h80, 0);
    start_s[0] = 1'b1; op_s[0] = 2'b10; addr_s[0] = 8'h50; wdata_s[0] = 8'h10;
    @(posedge clk); #1; start_s[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_s[0] = 1'b1;
    @(posedge clk); #1; rst_s[0] = 1'b0;
    mr[0] = 8'h00;
    checks++;
    if (busy_w[0] !== 1'b0 || done_w[0] !== 1'b0 || rdata_w[0] !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_fetch: busy=%b done=%b read_data=%h need 0 0 00", busy_w[0], done_w[0], rdata_w[0]);
    end
    do_req(0, 2'b01, 8'h50, 8'h00, 0);
  endtask

  task automatic test_back_to_back();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) do_req(d, 2'b01, 8'($urandom_range(0, dep(d) - 1)), 8'h00, 2);
      start_s[d] = 1'b0;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      for (int d = 0; d < 2; d++) do_req(d, 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom), 0);
    end
  endtask

  initial begin
    test_reset();
    test_fill(0);
    test_fill(1);
    test_write_read();
    test_fetch_add();
    test_wait_junk();
    test_range();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
